// File: rtl/float_sub_pipe_if.sv
// Handshake bundle for float_sub_pipe: operand input channel and result output channel.
interface float_sub_pipe_if #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
);
  localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              call_fRNG;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] data_out;

  modport master (
    output in_valid, a, b, call_fRNG, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, a, b, call_fRNG, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/float_sub_pipe.sv
// Three-stage floating-point subtractor (a - b) with flush-to-zero, truncation and
// an optional LFSR-sourced subtrahend; one global stall driven by output backpressure.
module float_sub_pipe #(
  parameter int unsigned EXP_W     = 5,
  parameter int unsigned MAN_W     = 10,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input logic            clock,
  input logic            reset,
  float_sub_pipe_if.slave bus
);
  localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
  localparam int unsigned MANT_W = MAN_W + 4;            // hidden + mantissa + 3 guard
  localparam int unsigned SUM_W  = MANT_W + 1;
  localparam int unsigned LZ_W   = $clog2(MANT_W) + 1;
  localparam int unsigned XE_W   = EXP_W + LZ_W + 1;
  localparam logic [EXP_W-1:0]  EXP_ONES = '1;
  localparam logic [WORD_W-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic              w_stall;
  logic              w_accept;
  logic [31:0]       r_lfsr;
  logic [31:0]       w_lfsr_next;
  logic [WORD_W-1:0] w_b;

  logic              w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_special;
  logic [EXP_W-1:0]  w_ea, w_eb, w_exp1, w_diff;
  logic [MANT_W-1:0] w_ma, w_mb, w_ma_al, w_mb_al;
  logic [WORD_W-1:0] w_spec_word;

  logic              r_v1, r_s1_sa, r_s1_sb, r_s1_special;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [MANT_W-1:0] r_s1_ma, r_s1_mb;
  logic [WORD_W-1:0] r_s1_word;

  logic              w_sign2;
  logic [SUM_W-1:0]  w_sum;

  logic              r_v2, r_s2_sign, r_s2_special;
  logic [EXP_W-1:0]  r_s2_exp;
  logic [SUM_W-1:0]  r_s2_sum;
  logic [WORD_W-1:0] r_s2_word;

  logic [LZ_W-1:0]   w_lzc;
  logic [XE_W-1:0]   w_e3;
  logic [MANT_W-1:0] w_mant3;
  logic [WORD_W-1:0] w_result;
  logic              w_unused;

  logic              r_out_valid;
  logic [WORD_W-1:0] r_data_out;

  assign w_stall       = r_out_valid && !bus.out_ready;
  assign w_accept      = bus.in_valid && !w_stall;
  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.data_out  = r_data_out;

  // Galois step for x^32+x^22+x^2+x+1, shifting toward bit 0
  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign w_b         = bus.call_fRNG ? r_lfsr[WORD_W-1:0] : bus.b;

  // S1: unpack, classify, align
  always_comb begin
    w_sa    = bus.a[WORD_W-1];
    w_ea    = bus.a[WORD_W-2:MAN_W];
    w_sb    = ~w_b[WORD_W-1];
    w_eb    = w_b[WORD_W-2:MAN_W];
    w_a_nan = (w_ea == EXP_ONES) && (bus.a[MAN_W-1:0] != '0);
    w_b_nan = (w_eb == EXP_ONES) && (w_b[MAN_W-1:0] != '0);
    w_a_inf = (w_ea == EXP_ONES) && (bus.a[MAN_W-1:0] == '0);
    w_b_inf = (w_eb == EXP_ONES) && (w_b[MAN_W-1:0] == '0);
    w_ma    = (w_ea == '0) ? '0 : {1'b1, bus.a[MAN_W-1:0], 3'b000};
    w_mb    = (w_eb == '0) ? '0 : {1'b1, w_b[MAN_W-1:0], 3'b000};

    if (w_ea >= w_eb) begin
      w_exp1  = w_ea;
      w_diff  = w_ea - w_eb;
      w_ma_al = w_ma;
      w_mb_al = (32'(w_diff) >= MANT_W) ? '0 : (w_mb >> w_diff);
    end else begin
      w_exp1  = w_eb;
      w_diff  = w_eb - w_ea;
      w_mb_al = w_mb;
      w_ma_al = (32'(w_diff) >= MANT_W) ? '0 : (w_ma >> w_diff);
    end

    w_special   = 1'b1;
    w_spec_word = QNAN;
    if (w_a_nan || w_b_nan)     w_spec_word = QNAN;
    else if (w_a_inf && w_b_inf) w_spec_word = (w_sa != w_sb) ? QNAN : {w_sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (w_a_inf)           w_spec_word = {w_sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (w_b_inf)           w_spec_word = {w_sb, EXP_ONES, {MAN_W{1'b0}}};
    else                        w_special   = 1'b0;
  end

  // S2: signed-magnitude add; the larger magnitude sets the sign on subtraction
  always_comb begin
    w_sum   = '0;
    w_sign2 = r_s1_sa;
    if (r_s1_sa == r_s1_sb) begin
      w_sum = {1'b0, r_s1_ma} + {1'b0, r_s1_mb};
    end else if (r_s1_ma >= r_s1_mb) begin
      w_sum = {1'b0, r_s1_ma} - {1'b0, r_s1_mb};
    end else begin
      w_sum   = {1'b0, r_s1_mb} - {1'b0, r_s1_ma};
      w_sign2 = r_s1_sb;
    end
  end

  // S3: normalise, range-check, pack
  always_comb begin
    w_lzc = '0;
    for (int unsigned i = 0; i < MANT_W; i++) begin
      if (r_s2_sum[i]) w_lzc = LZ_W'(MANT_W - 1 - i);
    end

    if (r_s2_sum[SUM_W-1]) begin
      w_e3    = XE_W'(r_s2_exp) + XE_W'(1);
      w_mant3 = r_s2_sum[SUM_W-1:1];
    end else begin
      w_e3    = XE_W'(r_s2_exp) - XE_W'(w_lzc);
      w_mant3 = r_s2_sum[MANT_W-1:0] << w_lzc;
    end

    if (r_s2_special)                    w_result = r_s2_word;
    else if (r_s2_sum == '0)             w_result = '0;
    else if (w_e3[XE_W-1] || w_e3 == '0) w_result = {r_s2_sign, {(WORD_W-1){1'b0}}};
    else if (w_e3 >= XE_W'(EXP_ONES))    w_result = {r_s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    else                                 w_result = {r_s2_sign, w_e3[EXP_W-1:0], w_mant3[MANT_W-2:3]};
  end

  assign w_unused = ^{w_mant3[MANT_W-1], w_mant3[2:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr      <= LFSR_SEED;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else if (!w_stall) begin
      if (w_accept) r_lfsr <= w_lfsr_next;
      r_v1        <= bus.in_valid;
      r_v2        <= r_v1;
      r_out_valid <= r_v2;
      if (r_v2) r_data_out <= w_result;
    end
  end

  always_ff @(posedge clock) begin
    if (!w_stall) begin
      if (w_accept) begin
        r_s1_sa      <= w_sa;
        r_s1_sb      <= w_sb;
        r_s1_exp     <= w_exp1;
        r_s1_ma      <= w_ma_al;
        r_s1_mb      <= w_mb_al;
        r_s1_special <= w_special;
        r_s1_word    <= w_spec_word;
      end
      if (r_v1) begin
        r_s2_sign    <= w_sign2;
        r_s2_exp     <= r_s1_exp;
        r_s2_sum     <= w_sum;
        r_s2_special <= r_s1_special;
        r_s2_word    <= r_s1_word;
      end
    end
  end
endmodule
